bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_data, input, WIDTH bits: parallel word to serialize.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 The block SHALL have port ser_out, output, 1 bit: serial bit stream feeding the downstream Mealy detector's in input.
REQ-008 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a frame bit this cycle.
REQ-009 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last bit of a frame.

Function
REQ-010 Handshake: a word SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_valid without in_ready SHALL be ignored.
REQ-011 States: IDLE, SHIFT, and PARITY (PARITY exists only when PAR_BIT_EN is defined).
REQ-012 IDLE SHALL drive in_ready=1, ser_valid=0, ser_out=0, and frame_done=0.
REQ-013 IDLE -> SHIFT on accept; the word SHALL be loaded into a WIDTH-bit shift register and the bit counter cleared.
REQ-014 Latency: in the cycle after acceptance, ser_out SHALL equal in_data[WIDTH-1]; bits then follow MSB first, one per cycle, for WIDTH cycles, with ser_valid=1.
REQ-015 The bit counter SHALL be $clog2(WIDTH) bits wide (minimum 1), SHALL count 0..WIDTH-1 in SHIFT, and SHALL never wrap inside a frame.
REQ-016 ser_out and ser_valid SHALL be registered outputs, with no combinational path from in_valid or in_data.
REQ-017 The last frame bit is bit 0 without parity, or the parity bit with parity. In that cycle, in_ready SHALL be 1 and frame_done SHALL be 1.
REQ-018 Back-to-back: an accept during the last-bit cycle SHALL reload the register, and the new word's MSB SHALL appear the next cycle with no gap (ser_valid stays 1).
REQ-019 If there is no accept in the last-bit cycle, the block SHALL return to IDLE and ser_valid SHALL drop to 0 the next cycle.
REQ-020 in_ready SHALL be 0 in every SHIFT cycle except the last-bit cycle.
REQ-021 Changes to in_data after acceptance SHALL not affect the frame in flight.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE and clear the shift register, bit counter, and parity accumulator.
REQ-023 After reset, the outputs SHALL be in_ready=1, ser_out=0, ser_valid=0, frame_done=0.
REQ-024 Reset mid-frame SHALL abort the frame: no further frame bits, and no frame_done.
REQ-025 reset SHALL dominate a simultaneous accept; the word presented in that cycle SHALL be dropped.

Configuration
REQ-026 Macro PAR_BIT_EN: when defined, after bit 0 the block SHALL spend one PARITY cycle outputting the even parity bit (XOR of all WIDTH data bits), with ser_valid=1. Frame length is WIDTH+1.
REQ-027 When PAR_BIT_EN is undefined, no PARITY state or parity logic SHALL exist. Frame length is WIDTH, and SHIFT goes directly to IDLE/SHIFT after bit 0.

Verification
REQ-028 Reset then idle, WIDTH=8: hold reset 2 cycles, release, in_valid=0 -> in_ready=1, ser_valid=0, ser_out=0 every cycle.
REQ-029 Single word, no parity: in_data=8'hA5 accepted at cycle 0 -> ser_out over cycles 1..8 = 1,0,1,0,0,1,0,1; frame_done=1 only at cycle 8; ser_valid=0 at cycle 9.
REQ-030 Parity: PAR_BIT_EN defined, 8'h07 -> bits 0,0,0,0,0,1,1,1 then parity 1 at cycle 9. 8'hA5 -> parity 0.
REQ-031 Back-to-back, no parity: 8'hFF at cycle 0, 8'h00 held valid -> accept at cycle 8, ser_out=1 for cycles 1..8 and 0 for cycles 9..16, ser_valid continuously 1, in_ready=1 only at cycles 0, 8, 16.
REQ-032 Busy ignore: in_valid held with 8'h3C during cycles 2..7 of an 8'hA5 frame -> 8'hA5 bit sequence unchanged; 8'h3C accepted at cycle 8.
REQ-033 Reset mid-frame: 8'hA5 accepted, reset at cycle 4 -> cycle 5 shows ser_valid=0, ser_out=0, in_ready=1, no frame_done pulse.

Source files
------------

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// bit_serializer : MSB-first parallel-to-serial converter with valid/ready
// intake. Optional even-parity trailer bit when PAR_BIT_EN is defined.
// Revision: 1.0
// ============================================================================
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done
);

  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef PAR_BIT_EN
    , ST_PARITY = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef PAR_BIT_EN
  logic             parity_q, parity_d;
`endif

  logic last_bit;
  logic accept;

  // Every output is decoded from flops only; in_valid/in_data never reach them.
  always_comb begin
    last_bit = 1'b0;
    ser_out  = 1'b0;
`ifdef PAR_BIT_EN
    if (state_q == ST_PARITY) begin
      last_bit = 1'b1;
      ser_out  = parity_q;
    end
`else
    if (state_q == ST_SHIFT && cnt_q == LAST_IDX) begin
      last_bit = 1'b1;
    end
`endif
    if (state_q == ST_SHIFT) begin
      ser_out = shreg_q[WIDTH-1];
    end
    in_ready   = (state_q == ST_IDLE) || last_bit;
    ser_valid  = (state_q != ST_IDLE);
    frame_done = last_bit;
    accept     = in_valid && in_ready;
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef PAR_BIT_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SHIFT;
          shreg_d  = in_data;
          cnt_d    = '0;
`ifdef PAR_BIT_EN
          parity_d = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`ifdef PAR_BIT_EN
        parity_d = parity_q ^ shreg_q[WIDTH-1];
        if (cnt_q == LAST_IDX) begin
          state_d = ST_PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        if (cnt_q == LAST_IDX) begin
          // Last data bit: reload immediately for a gapless next frame.
          if (accept) begin
            shreg_d = in_data;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
`ifdef PAR_BIT_EN
      ST_PARITY: begin
        if (accept) begin
          state_d  = ST_SHIFT;
          shreg_d  = in_data;
          cnt_d    = '0;
          parity_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PAR_BIT_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PAR_BIT_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// tb_bit_serializer : scoreboard bench for bit_serializer (WIDTH=8).
// Revision: 1.0
// ============================================================================
module tb_bit_serializer;

  localparam int WIDTH = 8;
`ifdef PAR_BIT_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic s_ready, s_sv, s_so, s_fd;

  task automatic push_word(input logic [WIDTH-1:0] w);
    exp_t e;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      e.b    = w[i];
`ifdef PAR_BIT_EN
      e.last = 1'b0;
`else
      e.last = (i == 0);
`endif
      exp_q.push_back(e);
    end
`ifdef PAR_BIT_EN
    e.b    = ^w;
    e.last = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  // One clock cycle: drive, sample at negedge, score the serial stream, advance.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rst);
    exp_t e;
    logic acc;
    reset    = rst;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    s_ready = in_ready;
    s_sv    = ser_valid;
    s_so    = ser_out;
    s_fd    = frame_done;
    acc     = v && s_ready && !rst;
    if (s_sv === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bit: ser_valid=1 ser_out=%b but no bit expected", s_so);
      end else begin
        e = exp_q.pop_front();
        if (s_so !== e.b) begin
          failures++;
          $display("FAIL ser_out: got %b expected %b", s_so, e.b);
        end
        checks++;
        if (s_fd !== e.last) begin
          failures++;
          $display("FAIL frame_done: got %b expected %b", s_fd, e.last);
        end
      end
    end else begin
      checks++;
      if (s_sv !== 1'b0 || s_so !== 1'b0 || s_fd !== 1'b0 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL idle_outputs: ser_valid=%b ser_out=%b frame_done=%b pending=%0d expected 0,0,0,0",
                 s_sv, s_so, s_fd, exp_q.size());
      end
    end
    if (acc) push_word(d);
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
  endtask

  task automatic test_reset;
    step(1'b0, '0, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, 1'b0);
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready: got %b expected 1", s_ready);
      end
    end
  endtask

  task automatic run_single(input logic [WIDTH-1:0] w);
    step(1'b1, w, 1'b0);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_accept_ready: got %b expected 1", s_ready);
    end
    for (int c = 1; c <= FLEN; c++) begin
      step(1'b0, ~w, 1'b0);
      checks++;
      if (s_sv !== 1'b1 || s_ready !== (c == FLEN)) begin
        failures++;
        $display("FAIL single_cycle%0d: ser_valid=%b in_ready=%b expected 1,%b",
                 c, s_sv, s_ready, (c == FLEN));
      end
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if (s_sv !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_end: ser_valid=%b in_ready=%b expected 0,1", s_sv, s_ready);
    end
  endtask

  task automatic test_single;
    run_single(8'hA5);
    run_single(8'h81);
  endtask

  task automatic test_parity;
`ifdef PAR_BIT_EN
    run_single(8'h07);
    run_single(8'hA5);
`endif
  endtask

  task automatic test_back_to_back;
    step(1'b1, 8'hFF, 1'b0);
    for (int c = 1; c <= FLEN; c++) begin
      step(1'b1, 8'h00, 1'b0);
      checks++;
      if (s_sv !== 1'b1 || s_ready !== (c == FLEN)) begin
        failures++;
        $display("FAIL b2b_first%0d: ser_valid=%b in_ready=%b expected 1,%b",
                 c, s_sv, s_ready, (c == FLEN));
      end
    end
    for (int c = FLEN + 1; c <= 2 * FLEN; c++) begin
      step(1'b0, 8'h00, 1'b0);
      checks++;
      if (s_sv !== 1'b1 || s_ready !== (c == 2 * FLEN)) begin
        failures++;
        $display("FAIL b2b_second%0d: ser_valid=%b in_ready=%b expected 1,%b",
                 c, s_sv, s_ready, (c == 2 * FLEN));
      end
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if (s_sv !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: ser_valid=%b expected 0", s_sv);
    end
  endtask

  task automatic test_busy_ignore;
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int c = 2; c <= FLEN; c++) begin
      step(1'b1, 8'h3C, 1'b0);
      checks++;
      if (s_ready !== (c == FLEN)) begin
        failures++;
        $display("FAIL busy_ready%0d: got %b expected %b", c, s_ready, (c == FLEN));
      end
    end
    for (int c = 0; c < FLEN; c++) step(1'b0, 8'hC3, 1'b0);
    step(1'b0, '0, 1'b0);
    checks++;
    if (s_sv !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL busy_end: ser_valid=%b pending=%0d expected 0,0", s_sv, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    step(1'b1, 8'hA5, 1'b0);
    for (int c = 1; c <= 3; c++) step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    checks++;
    if (s_sv !== 1'b0 || s_so !== 1'b0 || s_ready !== 1'b1 || s_fd !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: sv=%b so=%b rdy=%b fd=%b expected 0,0,1,0",
               s_sv, s_so, s_ready, s_fd);
    end
    for (int c = 0; c < FLEN; c++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
